// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus request/response types, AXI-style burst encodings and arbiter state.
package cbus_arbiter_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  // Next round-robin slot after idx, wrapping at n masters.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
    return ((int'(idx) + 1) >= n) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Round-robin priority picker: first valid master at or above i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] i_valid,
  input  logic [2:0]             i_ptr,
  output logic [2:0]             o_idx,
  output logic                   o_hit
);

  int j;

  always_comb begin
    o_idx = '0;
    o_hit = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = int'(i_ptr) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!o_hit && (k == j) && i_valid[k]) begin
          o_hit = 1'b1;
          o_idx = k[2:0];
        end
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// N:1 CBus arbiter: round-robin grant held for a whole burst, one dead cycle between owners.
// state | meaning
// IDLE  | no owner, downstream quiet, arbitrate on valid requests
// GRANT | sel owns the bus until a ready+last beat
// TURN  | one dead cycle so oreq.valid drops between transactions
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_MASTERS],
  output cbus_resp_t iresps [NUM_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  output logic       busy,
  output logic [2:0] grant_idx,
  output logic       proto_err
);

  arb_state_e            r_state;
  logic [2:0]            r_sel;
  logic [2:0]            r_rr_ptr;
  logic [7:0]            r_beat;
  logic                  r_proto_err;
  logic                  r_busy;
  logic [2:0]            r_grant_idx;

  logic [NUM_MASTERS-1:0] w_valid;
  logic [2:0]             w_pick_idx;
  logic                   w_pick_hit;
  cbus_req_t              w_sel_req;

  always_comb begin
    w_valid   = '0;
    w_sel_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_valid[i] = ireqs[i].valid;
      if (r_sel == i[2:0]) w_sel_req = ireqs[i];
    end
  end

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_rr_pick (
    .i_valid (w_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_hit   (w_pick_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_beat      <= '0;
      r_proto_err <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_hit) begin
            r_sel       <= w_pick_idx;
            r_grant_idx <= w_pick_idx;
            r_busy      <= 1'b1;
            r_beat      <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (oresp.ready) begin
            r_beat <= r_beat + 8'd1;
            if (oresp.last) begin
              // Last must land on the beat numbered len (beats count from 0).
              if (r_beat != w_sel_req.len) r_proto_err <= 1'b1;
              r_rr_ptr <= wrap_inc(r_sel, NUM_MASTERS);
              r_state  <= ST_TURN;
            end
          end
        end
        ST_TURN: begin
          r_busy      <= 1'b0;
          r_grant_idx <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Routing depends only on registered state, so oresp never reaches oreq.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_MASTERS; i++) iresps[i] = '0;
    if (r_state == ST_GRANT) begin
      oreq = w_sel_req;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (r_sel == i[2:0]) iresps[i] = oresp;
      end
    end
  end

  assign busy      = r_busy;
  assign grant_idx = r_grant_idx;
  assign proto_err = r_proto_err;

endmodule
